log2_round_pipe: RTL and testbench
==================================

Name: log2_round_pipe

Overview:
- Pipelined, parametrised integer log2 unit with selectable rounding: floor, round-to-nearest, or ceiling.
- Next generation of the team's combinational log2 used by the Welford extern's divide-by-shift path.
- Adds valid/ready handshake with backpressure, a per-transaction rounding mode, zero/one flags and a sideband tag passthrough.
- Sits between the Welford accumulator and the shift-divider, so the log2 no longer sits in one long combinational path.

Parameters:
- INPUT_WIDTH, 20: operand width; must be >= 2.
- OUTPUT_WIDTH, $clog2(INPUT_WIDTH+1): result width; large enough to hold the ceiling of an all-ones operand.
- TAG_WIDTH, 8: sideband tag width, carried unchanged alongside the operand.

Ports:
- axis_aclk  in  1  clock.
- axis_resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  unit accepts an operand this cycle.
- in_data  in  INPUT_WIDTH  unsigned operand.
- in_mode  in  2  rounding mode: 00 floor, 01 nearest, 10 ceil, 11 reserved (treated as floor).
- in_tag  in  TAG_WIDTH  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_result  out  OUTPUT_WIDTH  rounded log2.
- out_zero  out  1  operand was 0.
- out_one  out  1  operand was 1.
- out_tag  out  TAG_WIDTH  tag of this result.

Behaviour:
- Clock and reset: single clock domain (axis_aclk). axis_resetn is asynchronous, active-low.
- Reset values:
  - All valid bits of stages S1..S3 are 0, so out_valid=0.
  - out_result, out_zero, out_one and out_tag are 0.
  - in_ready is 1 once reset is released.
- Pipeline stages, fixed latency of 3 cycles from accept to out_valid when there is no stall:
  - S1 registers in_data, in_mode and in_tag.
  - S2 computes p = index of the leading 1 (priority encode), plus the flags below, and registers them.
    - rb = bit p-1; 0 if p=0.
    - st = OR of bits below p; 0 if p=0.
    - zero = (data==0); one = (data==1).
  - S3 applies rounding and registers the output.
- Stall rule: adv = !out_valid | out_ready.
  - When adv=0 every stage holds its contents.
  - in_ready = adv, combinational.
  - Bubbles are not squeezed out; the whole pipeline advances in lockstep.
- Handshakes:
  - An operand is accepted when in_valid & in_ready.
  - A result is consumed when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_* are held stable.
- Rounding, for an operand >= 2:
  - floor: p.
  - nearest: p + rb. Ties round up, e.g. 3 -> 2, 6 -> 3.
  - ceil: p + st. Exact powers of two are unchanged.
- Operand 0 or 1: out_result = 0 in every mode.
  - out_zero or out_one is set accordingly.
  - Downstream treats a 0 result as "do not divide".
- Width: the result never overflows OUTPUT_WIDTH. The maximum is ceil of (2^INPUT_WIDTH - 1) = INPUT_WIDTH.
- Mode 11 produces exactly the same result as mode 00.
- Throughput: 1 operand per cycle when out_ready is held high.
- Simultaneous accept and consume: allowed in the same cycle with no bubble.
- Reset asserted mid-operation: all in-flight operands are discarded with no output. out_valid drops immediately (asynchronously).
- Tags: each tag stays aligned with its own operand; ordering is strictly FIFO.

Test Plan:
- Floor mode, INPUT_WIDTH=20:
  - in_data 1, 2, 3, 1000, 0xFFFFF -> out_result 0, 1, 1, 9, 19.
  - out_one=1 only for the first operand.
  - Each result appears 3 cycles after acceptance.
- Nearest mode:
  - in_data 3, 5, 6, 12, 1000 (0b1111101000) -> out_result 2, 2, 3, 4, 10.
- Ceil mode:
  - in_data 4, 5, 1024, 1025, 0xFFFFF -> out_result 2, 3, 10, 11, 20.
- Zero operand:
  - in_data 0 in every mode -> out_result 0, out_zero=1, out_one=0.
  - Mode 11 with in_data 1000 -> out_result 9.
- Backpressure:
  - Stream 6 operands with tags 0..5 while out_ready toggles 1,0,0,1,...
  - Required: in_ready tracks adv each cycle, no operand is lost or duplicated, tags emerge 0..5 in order, and out_* stay stable while stalled.
- Reset mid-stream:
  - Drop axis_resetn with 3 operands in flight -> out_valid goes to 0 at once.
  - After release, no stale result appears.
  - The next operand (in_data 8, mode 00) produces out_result 3 after 3 cycles.

Source files
------------

// File: rtl/log2_round_pipe_if.sv
// Operand/result handshake bundle for log2_round_pipe.
// The master side drives operands and out_ready; the slave side is the log2 unit.
interface log2_round_pipe_if #(
    parameter int INPUT_WIDTH  = 20,
    parameter int OUTPUT_WIDTH = $clog2(INPUT_WIDTH + 1),
    parameter int TAG_WIDTH    = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [INPUT_WIDTH-1:0]  in_data;
    logic [1:0]              in_mode;
    logic [TAG_WIDTH-1:0]    in_tag;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUTPUT_WIDTH-1:0] out_result;
    logic                    out_zero;
    logic                    out_one;
    logic [TAG_WIDTH-1:0]    out_tag;

    modport master (
        output in_valid, in_data, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_one, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_one, out_tag
    );
endinterface

// File: rtl/log2_round_pipe.sv
// Three-stage integer log2 with floor / nearest / ceil rounding, zero/one flags
// and a tag passthrough; the whole pipe stalls in lockstep on output backpressure.
module log2_round_pipe #(
    parameter int INPUT_WIDTH  = 20,
    parameter int OUTPUT_WIDTH = $clog2(INPUT_WIDTH + 1),
    parameter int TAG_WIDTH    = 8
) (
    input  logic              axis_aclk,
    input  logic              axis_resetn,
    log2_round_pipe_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_FLOOR   = 2'b00,
        MODE_NEAREST = 2'b01,
        MODE_CEIL    = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    logic adv;

    // S1: operand capture
    logic                   s1_valid;
    logic [INPUT_WIDTH-1:0] s1_data;
    mode_e                  s1_mode;
    logic [TAG_WIDTH-1:0]   s1_tag;

    // S2: leading-one index and rounding bits
    logic                    s2_valid;
    logic [OUTPUT_WIDTH-1:0] s2_p;
    logic                    s2_rb;
    logic                    s2_st;
    logic                    s2_zero;
    logic                    s2_one;
    mode_e                   s2_mode;
    logic [TAG_WIDTH-1:0]    s2_tag;

    // S3: rounded result
    logic                    s3_valid;
    logic [OUTPUT_WIDTH-1:0] s3_result;
    logic                    s3_zero;
    logic                    s3_one;
    logic [TAG_WIDTH-1:0]    s3_tag;

    // Combinational stage logic
    int unsigned             lead_idx;
    logic                    rb_d;
    logic                    st_d;
    logic [OUTPUT_WIDTH-1:0] rounded;

    // Only a held, unconsumed result can stall; bubbles advance with everything else.
    assign adv          = !s3_valid || bus.out_ready;
    assign bus.in_ready = adv;

    assign bus.out_valid  = s3_valid;
    assign bus.out_result = s3_result;
    assign bus.out_zero   = s3_zero;
    assign bus.out_one    = s3_one;
    assign bus.out_tag    = s3_tag;

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= MODE_FLOOR;
            s1_tag   <= '0;
        end else if (adv) begin
            s1_valid <= bus.in_valid;
            s1_data  <= bus.in_data;
            s1_mode  <= mode_e'(bus.in_mode);
            s1_tag   <= bus.in_tag;
        end
    end

    always_comb begin
        lead_idx = 0;
        rb_d     = 1'b0;
        st_d     = 1'b0;
        for (int unsigned i = 0; i < INPUT_WIDTH; i++) begin
            if (s1_data[i]) lead_idx = i;
        end
        for (int unsigned i = 0; i < INPUT_WIDTH; i++) begin
            if (i + 1 == lead_idx) rb_d = s1_data[i];
            if (i < lead_idx)      st_d = st_d | s1_data[i];
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            s2_valid <= 1'b0;
            s2_p     <= '0;
            s2_rb    <= 1'b0;
            s2_st    <= 1'b0;
            s2_zero  <= 1'b0;
            s2_one   <= 1'b0;
            s2_mode  <= MODE_FLOOR;
            s2_tag   <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_p     <= OUTPUT_WIDTH'(lead_idx);
            s2_rb    <= rb_d;
            s2_st    <= st_d;
            s2_zero  <= (s1_data == '0);
            s2_one   <= (s1_data == INPUT_WIDTH'(1));
            s2_mode  <= s1_mode;
            s2_tag   <= s1_tag;
        end
    end

    // p+1 tops out at INPUT_WIDTH, which OUTPUT_WIDTH always holds.
    always_comb begin
        rounded = s2_p;
        case (s2_mode)
            MODE_NEAREST: rounded = s2_p + OUTPUT_WIDTH'(s2_rb);
            MODE_CEIL:    rounded = s2_p + OUTPUT_WIDTH'(s2_st);
            default:      rounded = s2_p;
        endcase
        if (s2_zero || s2_one) rounded = '0;
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            s3_valid  <= 1'b0;
            s3_result <= '0;
            s3_zero   <= 1'b0;
            s3_one    <= 1'b0;
            s3_tag    <= '0;
        end else if (adv) begin
            s3_valid  <= s2_valid;
            s3_result <= rounded;
            s3_zero   <= s2_zero;
            s3_one    <= s2_one;
            s3_tag    <= s2_tag;
        end
    end

endmodule

// File: tb/tb_log2_round_pipe.sv
// Directed bench for log2_round_pipe: rounding modes, flags, latency,
// backpressure ordering/stability and mid-stream reset.
module tb_log2_round_pipe;

    localparam int IW = 20;
    localparam int OW = 5;
    localparam int TW = 8;

    typedef struct {
        logic [31:0] res;
        logic [31:0] zero;
        logic [31:0] one;
        logic [31:0] tag;
        int          acc;
        bit          lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    log2_round_pipe_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .TAG_WIDTH(TW)) bus ();

    log2_round_pipe #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .TAG_WIDTH(TW)) dut (
        .axis_aclk   (clk),
        .axis_resetn (rst_n),
        .bus         (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the operand was accepted.
    task automatic send(input logic [31:0] d, input logic [1:0] m, input logic [7:0] t,
                        input logic [31:0] er, input logic [31:0] ez, input logic [31:0] eo,
                        input bit lat);
        exp_t e;
        int   n;
        bus.in_valid = 1'b1;
        bus.in_data  = IW'(d);
        bus.in_mode  = m;
        bus.in_tag   = t;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 50);
        chk("accept_timeout", 32'(bus.in_ready), 32'd1);
        e.res = er; e.zero = ez; e.one = eo; e.tag = 32'(t); e.acc = cyc; e.lat = lat;
        if (bus.in_ready) exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic                 stalled;
        logic [OW-1:0]        held_res;
        logic [TW-1:0]        held_tag;
        exp_t                 e;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = 2'b00;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        stalled       = 1'b0;
        held_res      = '0;
        held_tag      = '0;

        // Output monitor: ordering, values, latency, stall stability, in_ready rule.
        fork
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    stalled = 1'b0;
                end else begin
                    chk("in_ready_adv", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
                    if (stalled) begin
                        chk("hold_valid", 32'(bus.out_valid), 32'd1);
                        chk("hold_result", 32'(bus.out_result), 32'(held_res));
                        chk("hold_tag", 32'(bus.out_tag), 32'(held_tag));
                    end
                    if (bus.out_valid && bus.out_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("stray_output", 32'(bus.out_valid), 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("result", 32'(bus.out_result), e.res);
                            chk("zero", 32'(bus.out_zero), e.zero);
                            chk("one", 32'(bus.out_one), e.one);
                            chk("tag", 32'(bus.out_tag), e.tag);
                            if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd3);
                        end
                    end
                    stalled  = bus.out_valid && !bus.out_ready;
                    held_res = bus.out_result;
                    held_tag = bus.out_tag;
                end
            end
        join_none

        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_result", 32'(bus.out_result), 32'd0);
        chk("rst_out_zero", 32'(bus.out_zero), 32'd0);
        chk("rst_out_one", 32'(bus.out_one), 32'd0);
        chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
        #22;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

        // Floor, back to back, fixed 3-cycle latency
        send(1,       2'b00, 8'h01, 0,  0, 1, 1'b1);
        send(2,       2'b00, 8'h02, 1,  0, 0, 1'b1);
        send(3,       2'b00, 8'h03, 1,  0, 0, 1'b1);
        send(1000,    2'b00, 8'h04, 9,  0, 0, 1'b1);
        send(20'hFFFFF, 2'b00, 8'h05, 19, 0, 0, 1'b1);
        drain();

        // Nearest, ties round up
        send(3,    2'b01, 8'h11, 2,  0, 0, 1'b1);
        send(5,    2'b01, 8'h12, 2,  0, 0, 1'b1);
        send(6,    2'b01, 8'h13, 3,  0, 0, 1'b1);
        send(12,   2'b01, 8'h14, 4,  0, 0, 1'b1);
        send(1000, 2'b01, 8'h15, 10, 0, 0, 1'b1);
        send(2,    2'b01, 8'h16, 1,  0, 0, 1'b1);
        send(1,    2'b01, 8'h17, 0,  0, 1, 1'b1);
        drain();

        // Ceil, powers of two unchanged, all-ones reaches INPUT_WIDTH
        send(4,       2'b10, 8'h21, 2,  0, 0, 1'b1);
        send(5,       2'b10, 8'h22, 3,  0, 0, 1'b1);
        send(1024,    2'b10, 8'h23, 10, 0, 0, 1'b1);
        send(1025,    2'b10, 8'h24, 11, 0, 0, 1'b1);
        send(20'hFFFFF, 2'b10, 8'h25, 20, 0, 0, 1'b1);
        send(1,       2'b10, 8'h26, 0,  0, 1, 1'b1);
        drain();

        // Zero in every mode, reserved mode behaves as floor
        send(0,    2'b00, 8'h31, 0, 1, 0, 1'b1);
        send(0,    2'b01, 8'h32, 0, 1, 0, 1'b1);
        send(0,    2'b10, 8'h33, 0, 1, 0, 1'b1);
        send(0,    2'b11, 8'h34, 0, 1, 0, 1'b1);
        send(1000, 2'b11, 8'h35, 9, 0, 0, 1'b1);
        send(7,    2'b11, 8'h36, 2, 0, 0, 1'b1);
        drain();

        // Backpressure: out_ready pattern 1,0,0 repeating
        fork
            begin
                send(2,         2'b00, 8'd0, 1,  0, 0, 1'b0);
                send(3,         2'b01, 8'd1, 2,  0, 0, 1'b0);
                send(5,         2'b10, 8'd2, 3,  0, 0, 1'b0);
                send(7,         2'b00, 8'd3, 2,  0, 0, 1'b0);
                send(1000,      2'b01, 8'd4, 10, 0, 0, 1'b0);
                send(20'hFFFFF, 2'b10, 8'd5, 20, 0, 0, 1'b0);
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    bus.out_ready = (k % 3 == 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();

        // Reset with three operands in flight
        send(4,  2'b00, 8'h41, 2, 0, 0, 1'b0);
        send(9,  2'b01, 8'h42, 3, 0, 0, 1'b0);
        send(17, 2'b10, 8'h43, 5, 0, 0, 1'b0);
        chk("inflight_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_out_tag", 32'(bus.out_tag), 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_idle_valid", 32'(bus.out_valid), 32'd0);
        send(8, 2'b00, 8'h50, 3, 0, 0, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
